fpm_result_stage: RTL and testbench
===================================

// Module: fpm_result_stage
// PURPOSE
// - Registered output stage directly downstream of the combinational FP32 multiplier.
// - Captures each product (fp_Z, ovrf, udrf) plus a caller tag through a valid/ready handshake.
// - A 2-entry skid buffer (main + skid) isolates the multiplier from consumer back-pressure.
// - Keeps sticky exception flags for software, with an explicit clear input.
// PARAMETERS
// - TAG_W  4   width of the opaque tag carried alongside each result
// - CNT_W  16  width of the optional saturating event counters (FPM_EVT_CNT_EN only)
// PORTS
// - clk          in   1      single clock; all state updates on rising edge
// - rst          in   1      synchronous, active-high reset
// - in_valid     in   1      multiplier result valid this cycle
// - in_ready     out  1      stage can accept a beat this cycle
// - in_z         in   32     fp_Z from multiplier {sign, exp[7:0], frac[22:0]}
// - in_ovrf      in   1      multiplier overflow flag
// - in_udrf      in   1      multiplier underflow flag
// - in_tag       in   TAG_W  caller tag, passed through unchanged
// - out_valid    out  1      out_* holds a valid result
// - out_ready    in   1      consumer accepts the result this cycle
// - out_z        out  32     registered result
// - out_ovrf     out  1      registered overflow flag of this beat
// - out_udrf     out  1      registered underflow flag of this beat
// - out_tag      out  TAG_W  registered tag of this beat
// - flags_sticky out  2      {ovf, udf}; accumulated since last clear
// - flag_clr     in   1      clear sticky flags (and counters)
// BEHAVIOUR
// - Reset: out_valid=0, skid empty, flags_sticky=0, counters=0.
//   out_z, out_tag, out_ovrf and out_udrf read 0.
//   in_ready=0 while rst is high; in_ready=1 in the first cycle after release.
// - Handshakes: input accept = in_valid & in_ready; output transfer = out_valid & out_ready.
//   Payload is sampled only on accept. Holding in_valid without in_ready has no effect.
// - in_ready is registered and equals !skid_valid, so it has no combinational path from out_ready.
// - Latency: an accepted beat appears on out_* in the next cycle when main is empty or draining.
// - Main register:
//   - Loads on accept when main is empty, or when main is draining (out_ready=1) and skid is empty.
//   - Otherwise an accepted beat goes to skid; this happens only when main is full and out_ready=0.
// - Skid drain: on an output transfer with skid full, skid moves to main in that same cycle.
//   skid_valid clears, in_ready rises next cycle. Accept is impossible that cycle (in_ready=0).
// - Order: strict FIFO; no beat is lost or duplicated. Max occupancy is 2.
// - out_* stay stable while out_valid=1 and out_ready=0.
// - Sticky flags:
//   - flags_sticky[1] |= in_ovrf and flags_sticky[0] |= in_udrf on accept, not on output.
//   - flag_clr and a setting accept in the same cycle: the set wins, so the new event is kept.
//   - flag_clr alone zeroes both bits next cycle.
// - Mid-operation reset: all buffered beats are discarded, with no output transfer signalled.
// CONFIGURATION
// - Macro FPM_EVT_CNT_EN.
// - Defined:
//   - Adds outputs ovf_cnt and udf_cnt, each CNT_W bits.
//   - Each counter increments by 1 on an accept carrying the corresponding flag.
//   - Counters saturate at all-ones and do not wrap.
//   - flag_clr zeroes them; a same-cycle increment wins, giving value 1.
// - Undefined: no counter ports and no counter logic; all other behaviour is identical.
// STRUCTURE
// - fpm_pkg holds:
//   - typedef fp32_t (packed struct sign/exp/frac)
//   - typedef fpm_res_t {fp32_t z; logic ovrf, udrf; tag}
//   - constant FP32_W=32, sticky flag index constants FLG_OVF=1, FLG_UDF=0
// - Sub-module fpm_skid_buf: generic 2-entry valid/ready skid on fpm_res_t.
//   The top-level holds the sticky flags and counters.
// TESTING
// - Reset, then one beat: in_z=32'h40C00000, tag=3, out_ready=1.
//   -> next cycle out_valid=1, out_z=32'h40C00000, out_tag=3, then out_valid=0.
// - out_ready=0, send beats A=32'h3F800000 then B=32'h40000000.
//   -> in_ready=0 after B. Raise out_ready -> A then B on consecutive cycles, in_ready=1 after.
// - Beat with in_ovrf=1 and in_z=32'h7F800000.
//   -> flags_sticky=2'b10, holding through later clean beats. flag_clr -> 2'b00 next cycle.
// - flag_clr=1 in the same cycle as accepting a beat with in_udrf=1.
//   -> flags_sticky=2'b01; with FPM_EVT_CNT_EN, udf_cnt=1.
// - Assert rst for 1 cycle with main and skid full.
//   -> out_valid=0 and flags_sticky=0. No stale beat ever appears on out_*.
// - FPM_EVT_CNT_EN with CNT_W=2: five ovrf beats -> ovf_cnt reads 1,2,3,3,3.

Source files
------------

// File: rtl/fpm_pkg.sv
// Shared types and constants for the FP32 multiplier result stage.
package fpm_pkg;

  localparam int FP32_W    = 32;
  localparam int FPM_TAG_W = 4;
  localparam int FLG_OVF   = 1;
  localparam int FLG_UDF   = 0;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef struct packed {
    fp32_t                 z;
    logic                  ovrf;
    logic                  udrf;
    logic [FPM_TAG_W-1:0]  tag;
  } fpm_res_t;

  // Builds a sticky-flag vector laid out as {ovf, udf}.
  function automatic logic [1:0] flag_vec(input logic ovf, input logic udf);
    logic [1:0] v;
    v          = 2'b00;
    v[FLG_OVF] = ovf;
    v[FLG_UDF] = udf;
    return v;
  endfunction

endpackage

// File: rtl/fpm_skid_buf.sv
// Generic 2-entry valid/ready skid buffer (main + skid) with a registered in_ready.
module fpm_skid_buf
  import fpm_pkg::*;
#(
  parameter type T = fpm_res_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  T     main_r, skid_r;
  T     main_nxt_s, skid_nxt_s;
  logic main_valid_r, skid_valid_r, in_ready_r;
  logic main_valid_nxt_s, skid_valid_nxt_s;
  logic accept_s, xfer_s;

  assign accept_s  = in_valid & in_ready_r;
  assign xfer_s    = main_valid_r & out_ready;
  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_data  = main_r;

  // Next-state selection; accept and skid drain never coincide because in_ready is low while skid is full.
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (xfer_s && skid_valid_r) begin
      main_nxt_s       = skid_r;
      skid_valid_nxt_s = 1'b0;
    end else if (accept_s && (!main_valid_r || xfer_s)) begin
      main_nxt_s       = in_data;
      main_valid_nxt_s = 1'b1;
    end else if (accept_s) begin
      skid_nxt_s       = in_data;
      skid_valid_nxt_s = 1'b1;
    end else if (xfer_s) begin
      main_valid_nxt_s = 1'b0;
    end else begin
      main_valid_nxt_s = main_valid_r;
    end
  end

  // Buffer state registers; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= ~skid_valid_nxt_s;
    end
  end

endmodule

// File: rtl/fpm_result_stage.sv
// Registered FP32 multiplier result stage: skid-buffered handshake plus sticky exception flags.
// Optional saturating event counters are enabled by defining FPM_EVT_CNT_EN.
module fpm_result_stage
  import fpm_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_z,
  input  logic              in_ovrf,
  input  logic              in_udrf,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_z,
  output logic              out_ovrf,
  output logic              out_udrf,
  output logic [TAG_W-1:0]  out_tag,
  output logic [1:0]        flags_sticky,
  input  logic              flag_clr
`ifdef FPM_EVT_CNT_EN
  ,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic [CNT_W-1:0]  udf_cnt
`endif
);

  typedef struct packed {
    fp32_t             z;
    logic              ovrf;
    logic              udrf;
    logic [TAG_W-1:0]  tag;
  } res_t;

  res_t       in_res_s, out_res_s;
  logic       accept_s;
  logic [1:0] set_s, flags_nxt_s, flags_r;

  assign in_res_s = {in_z, in_ovrf, in_udrf, in_tag};

  fpm_skid_buf #(.T(res_t)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_res_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_res_s)
  );

  assign accept_s     = in_valid & in_ready;
  assign out_z        = out_res_s.z;
  assign out_ovrf     = out_res_s.ovrf;
  assign out_udrf     = out_res_s.udrf;
  assign out_tag      = out_res_s.tag;
  assign flags_sticky = flags_r;

  // Sticky flag update: a same-cycle setting accept survives a clear.
  always_comb begin
    set_s       = 2'b00;
    flags_nxt_s = flags_r;
    if (accept_s) begin
      set_s = flag_vec(in_ovrf, in_udrf);
    end else begin
      set_s = 2'b00;
    end
    if (flag_clr) begin
      flags_nxt_s = set_s;
    end else begin
      flags_nxt_s = flags_r | set_s;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_r <= 2'b00;
    end else begin
      flags_r <= flags_nxt_s;
    end
  end

`ifdef FPM_EVT_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] ovf_cnt_r, udf_cnt_r, ovf_cnt_nxt_s, udf_cnt_nxt_s;

  // Saturating counter next values; clear with a same-cycle event yields one.
  always_comb begin
    ovf_cnt_nxt_s = ovf_cnt_r;
    udf_cnt_nxt_s = udf_cnt_r;
    if (flag_clr) begin
      ovf_cnt_nxt_s = set_s[FLG_OVF] ? CNT_ONE : {CNT_W{1'b0}};
      udf_cnt_nxt_s = set_s[FLG_UDF] ? CNT_ONE : {CNT_W{1'b0}};
    end else begin
      if (set_s[FLG_OVF] && (ovf_cnt_r != CNT_MAX)) begin
        ovf_cnt_nxt_s = ovf_cnt_r + CNT_ONE;
      end else begin
        ovf_cnt_nxt_s = ovf_cnt_r;
      end
      if (set_s[FLG_UDF] && (udf_cnt_r != CNT_MAX)) begin
        udf_cnt_nxt_s = udf_cnt_r + CNT_ONE;
      end else begin
        udf_cnt_nxt_s = udf_cnt_r;
      end
    end
  end

  // Event counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_r <= {CNT_W{1'b0}};
      udf_cnt_r <= {CNT_W{1'b0}};
    end else begin
      ovf_cnt_r <= ovf_cnt_nxt_s;
      udf_cnt_r <= udf_cnt_nxt_s;
    end
  end

  assign ovf_cnt = ovf_cnt_r;
  assign udf_cnt = udf_cnt_r;
`else
  // Counters are absent; CNT_W stays in the interface so both builds share one parameter list.
  if (CNT_W > 0) begin : g_no_cnt
  end
`endif

endmodule

// File: tb/tb_fpm_result_stage.sv
// Scoreboard bench for fpm_result_stage: directed beats, queue of expected outputs, negedge monitor.
module tb_fpm_result_stage;

  localparam int TAG_W = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic [31:0]      z;
    logic             ovrf;
    logic             udrf;
    logic [TAG_W-1:0] tag;
  } beat_t;

  logic             clk, rst;
  logic             in_valid, in_ready, in_ovrf, in_udrf;
  logic [31:0]      in_z;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready, out_ovrf, out_udrf;
  logic [31:0]      out_z;
  logic [TAG_W-1:0] out_tag;
  logic [1:0]       flags_sticky;
  logic             flag_clr;
`ifdef FPM_EVT_CNT_EN
  logic [CNT_W-1:0] ovf_cnt, udf_cnt;
`endif

  int    tests = 0;
  int    fails = 0;
  beat_t exp_q[$];

  fpm_result_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_z         (in_z),
    .in_ovrf      (in_ovrf),
    .in_udrf      (in_udrf),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_z        (out_z),
    .out_ovrf     (out_ovrf),
    .out_udrf     (out_udrf),
    .out_tag      (out_tag),
    .flags_sticky (flags_sticky),
    .flag_clr     (flag_clr)
`ifdef FPM_EVT_CNT_EN
    ,
    .ovf_cnt      (ovf_cnt),
    .udf_cnt      (udf_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat, wait (bounded) for acceptance, record the expected output.
  task automatic send(input logic [31:0] z, input logic ov, input logic ud, input logic [TAG_W-1:0] tag);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_z     = z;
    in_ovrf  = ov;
    in_udrf  = ud;
    in_tag   = tag;
    while (!in_ready && n < 50) begin
      cycles(1);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready stuck low for tag %0d", tag);
    end else begin
      exp_q.push_back({z, ov, ud, tag});
      cycles(1);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the oldest expected beat.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got z=%h tag=%0d with empty scoreboard", out_z, out_tag);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("out_beat", {26'd0, out_z, out_ovrf, out_udrf, out_tag}, {26'd0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_z      = 32'h0;
    in_ovrf   = 1'b0;
    in_udrf   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
    cycles(2);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_z", out_z, 32'h0);
    check("rst_out_tag", out_tag, '0);
    check("rst_out_flags", {out_ovrf, out_udrf}, 2'b00);
    check("rst_sticky", flags_sticky, 2'b00);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    cycles(1);
    check("in_ready_after_rst", in_ready, 1'b1);

    // Single beat, consumer ready
    out_ready = 1'b1;
    send(32'h40C00000, 1'b0, 1'b0, 4'd3);
    check("t1_out_valid", out_valid, 1'b1);
    check("t1_out_z", out_z, 32'h40C00000);
    check("t1_out_tag", out_tag, 4'd3);
    cycles(1);
    check("t1_out_valid_drop", out_valid, 1'b0);

    // Back-pressure fills main then skid
    out_ready = 1'b0;
    send(32'h3F800000, 1'b0, 1'b0, 4'd1);
    check("t2_in_ready_after_a", in_ready, 1'b1);
    send(32'h40000000, 1'b0, 1'b0, 4'd2);
    check("t2_in_ready_after_b", in_ready, 1'b0);
    check("t2_out_z_a", out_z, 32'h3F800000);
    cycles(2);
    check("t2_stable_valid", out_valid, 1'b1);
    check("t2_stable_z", out_z, 32'h3F800000);
    check("t2_stable_tag", out_tag, 4'd1);
    out_ready = 1'b1;
    cycles(1);
    check("t2_out_z_b", out_z, 32'h40000000);
    check("t2_in_ready_back", in_ready, 1'b1);
    cycles(1);
    check("t2_drained", out_valid, 1'b0);

    // Sticky overflow, held through clean beats, then cleared
    send(32'h7F800000, 1'b1, 1'b0, 4'd4);
    check("t3_sticky_set", flags_sticky, 2'b10);
    send(32'h3F800000, 1'b0, 1'b0, 4'd5);
    send(32'h40000000, 1'b0, 1'b0, 4'd6);
    check("t3_sticky_hold", flags_sticky, 2'b10);
    flag_clr = 1'b1;
    cycles(1);
    flag_clr = 1'b0;
    check("t3_sticky_clr", flags_sticky, 2'b00);

    // Clear coincident with an underflow accept
    send(32'h7F800000, 1'b1, 1'b0, 4'd7);
    flag_clr = 1'b1;
    send(32'h00000000, 1'b0, 1'b1, 4'd8);
    flag_clr = 1'b0;
    check("t4_sticky_clr_set", flags_sticky, 2'b01);
`ifdef FPM_EVT_CNT_EN
    check("t4_udf_cnt", udf_cnt, 2'd1);
    check("t4_ovf_cnt", ovf_cnt, 2'd0);
`endif

    // Reset with main and skid full: nothing stale may emerge
    cycles(1);
    out_ready = 1'b0;
    send(32'h3F800000, 1'b1, 1'b0, 4'd9);
    send(32'h40000000, 1'b0, 1'b1, 4'd10);
    check("t5_full_in_ready", in_ready, 1'b0);
    check("t5_full_sticky", flags_sticky, 2'b11);
    rst = 1'b1;
    cycles(1);
    exp_q.delete();
    check("t5_rst_out_valid", out_valid, 1'b0);
    check("t5_rst_sticky", flags_sticky, 2'b00);
    check("t5_rst_in_ready", in_ready, 1'b0);
    rst       = 1'b0;
    out_ready = 1'b1;
    cycles(1);
    check("t5_in_ready_release", in_ready, 1'b1);
    check("t5_no_stale_valid", out_valid, 1'b0);
    cycles(3);
    check("t5_still_empty", out_valid, 1'b0);

`ifdef FPM_EVT_CNT_EN
    // Saturation with a 2-bit counter
    for (int i = 1; i <= 5; i++) begin
      send(32'h7F800000, 1'b1, 1'b0, 4'(i));
      check("t6_ovf_cnt", ovf_cnt, (i > 3) ? 2'd3 : 2'(i));
    end
`endif

    cycles(3);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d beats never appeared, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
